// File: rtl/multi_button_debouncer.sv
// Multi-channel button debouncer: two-flop synchroniser, per-channel stability
// counter, and one-cycle press / release / hold event pulses.
module multi_button_debouncer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DEBOUNCE_COUNT = 65_536,
  parameter int HOLD_TICKS     = 32,
  parameter bit HOLD_REPEAT    = 1'b0,
  parameter bit IN_ACTIVE_LOW  = 1'b1,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_CHANNELS-1:0] in_sig,
  output logic [NUM_CHANNELS-1:0] out_level,
  output logic [NUM_CHANNELS-1:0] press_pulse,
  output logic [NUM_CHANNELS-1:0] release_pulse,
  output logic [NUM_CHANNELS-1:0] hold_pulse
);

  localparam int CTR_W  = $clog2(DEBOUNCE_COUNT);
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [CTR_W-1:0]        CTR_LAST  = CTR_W'(DEBOUNCE_COUNT - 1);
  localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [NUM_CHANNELS-1:0] IN_IDLE   = {NUM_CHANNELS{IN_ACTIVE_LOW}};
  localparam logic [NUM_CHANNELS-1:0] OUT_IDLE  = {NUM_CHANNELS{OUT_ACTIVE_LOW}};

  logic [NUM_CHANNELS-1:0] sync_p0;
  logic [NUM_CHANNELS-1:0] sync_p1;
  logic [NUM_CHANNELS-1:0] act_p1;
  logic [NUM_CHANNELS-1:0] prev_p2;
  logic [NUM_CHANNELS-1:0] tick_p2;
  logic [CTR_W-1:0]        ctr_p2 [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] level_p3;
  logic [NUM_CHANNELS-1:0] press_p3;
  logic [NUM_CHANNELS-1:0] release_p3;
  logic [NUM_CHANNELS-1:0] hold_p3;
  logic [NUM_CHANNELS-1:0] hold_done_p3;
  logic [HOLD_W-1:0]       hold_ctr_p3 [NUM_CHANNELS];

  // Stage p1: synchronised input normalised to active-high
  assign act_p1 = IN_ACTIVE_LOW ? ~sync_p1 : sync_p1;

  // Stage p2: stable_tick fires when the input has been unchanged for a full period
  always_comb begin
    tick_p2 = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      tick_p2[i] = (act_p1[i] == prev_p2[i]) && (ctr_p2[i] == CTR_LAST);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0      <= IN_IDLE;
      sync_p1      <= IN_IDLE;
      prev_p2      <= '0;
      level_p3     <= '0;
      press_p3     <= '0;
      release_p3   <= '0;
      hold_p3      <= '0;
      hold_done_p3 <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ctr_p2[i]      <= '0;
        hold_ctr_p3[i] <= '0;
      end
    end else begin
      sync_p0    <= in_sig;
      sync_p1    <= sync_p0;
      prev_p2    <= act_p1;
      press_p3   <= '0;
      release_p3 <= '0;
      hold_p3    <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (act_p1[i] != prev_p2[i] || ctr_p2[i] == CTR_LAST) begin
          ctr_p2[i] <= '0;
        end else begin
          ctr_p2[i] <= ctr_p2[i] + 1'b1;
        end

        // Stage p3: accepted level changes and hold timing, once per stable period
        if (tick_p2[i]) begin
          if (act_p1[i] != level_p3[i]) begin
            level_p3[i]     <= act_p1[i];
            press_p3[i]     <= act_p1[i];
            release_p3[i]   <= ~act_p1[i];
            hold_ctr_p3[i]  <= '0;
            hold_done_p3[i] <= 1'b0;
          end else if (level_p3[i] && !hold_done_p3[i]) begin
            if (hold_ctr_p3[i] == HOLD_LAST) begin
              hold_p3[i]      <= 1'b1;
              hold_ctr_p3[i]  <= '0;
              hold_done_p3[i] <= ~HOLD_REPEAT;
            end else begin
              hold_ctr_p3[i] <= hold_ctr_p3[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  assign out_level     = level_p3   ^ OUT_IDLE;
  assign press_pulse   = press_p3   ^ OUT_IDLE;
  assign release_pulse = release_p3 ^ OUT_IDLE;
  assign hold_pulse    = hold_p3    ^ OUT_IDLE;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus random bounce,
// checked every cycle against a time-based reference model (two hold modes).
module tb_multi_button_debouncer;
  localparam int NC = 4;
  localparam int D  = 8;
  localparam int H  = 3;
  localparam bit IAL = 1'b1;
  localparam bit OAL = 1'b0;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [NC-1:0] in_sig;
  logic [NC-1:0] lvl0, pr0, rl0, hd0;
  logic [NC-1:0] lvl1, pr1, rl1, hd1;

  always #5 sys_clk = ~sys_clk;

  multi_button_debouncer #(.NUM_CHANNELS(NC), .DEBOUNCE_COUNT(D), .HOLD_TICKS(H),
    .HOLD_REPEAT(1'b0), .IN_ACTIVE_LOW(IAL), .OUT_ACTIVE_LOW(OAL)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_sig(in_sig), .out_level(lvl0),
    .press_pulse(pr0), .release_pulse(rl0), .hold_pulse(hd0));

  multi_button_debouncer #(.NUM_CHANNELS(NC), .DEBOUNCE_COUNT(D), .HOLD_TICKS(H),
    .HOLD_REPEAT(1'b1), .IN_ACTIVE_LOW(IAL), .OUT_ACTIVE_LOW(OAL)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_sig(in_sig), .out_level(lvl1),
    .press_pulse(pr1), .release_pulse(rl1), .hold_pulse(hd1));

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Reference model: a channel's active level a(t) is the raw input two edges
  // late; a stable period ends every D edges after the last change of a.
  int            r_edge;
  int            m_since [NC];
  bit            m_anow  [NC];
  bit            m_aold  [NC];
  bit            m_raw   [NC];
  int            m_hcnt  [2][NC];
  bit            m_hdone [2][NC];
  logic [NC-1:0] m_lvl, m_pr, m_rl;
  logic [NC-1:0] m_hd [2];

  // Observed-event records for the directed scenarios
  int            n_press [NC], last_press [NC], n_rel [NC], last_rel [NC];
  int            n_hold0 [NC], first_hold0 [NC], n_hold1 [NC];
  int            hold1_q [$];
  logic [NC-1:0] pv;
  int            pv_t;

  function automatic bit act(input bit r);
    return IAL ? ~r : r;
  endfunction

  task automatic clr();
    for (int c = 0; c < NC; c++) begin
      n_press[c] = 0; last_press[c] = -1; n_rel[c] = 0; last_rel[c] = -1;
      n_hold0[c] = 0; first_hold0[c] = -1; n_hold1[c] = 0;
    end
    hold1_q.delete();
    pv = '0;
    pv_t = -1;
  endtask

  task automatic model_edge();
    m_pr = '0; m_rl = '0; m_hd[0] = '0; m_hd[1] = '0;
    if (sys_rst) begin
      r_edge = t;
      m_lvl  = '0;
      for (int c = 0; c < NC; c++) begin
        m_since[c] = t; m_anow[c] = 1'b0; m_aold[c] = 1'b0; m_raw[c] = in_sig[c];
        for (int v = 0; v < 2; v++) begin m_hcnt[v][c] = 0; m_hdone[v][c] = 1'b0; end
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit av, ap;
        av = m_anow[c];
        ap = m_aold[c];
        if (t - r_edge >= 2 && av != ap) begin
          m_since[c] = t;
        end else if ((t - m_since[c]) % D == 0) begin
          if (av != m_lvl[c]) begin
            m_lvl[c] = av;
            if (av) m_pr[c] = 1'b1; else m_rl[c] = 1'b1;
            for (int v = 0; v < 2; v++) begin m_hcnt[v][c] = 0; m_hdone[v][c] = 1'b0; end
          end else if (m_lvl[c]) begin
            for (int v = 0; v < 2; v++) begin
              if (!m_hdone[v][c]) begin
                m_hcnt[v][c]++;
                if (m_hcnt[v][c] == H) begin
                  m_hd[v][c]    = 1'b1;
                  m_hcnt[v][c]  = 0;
                  m_hdone[v][c] = (v == 0);
                end
              end
            end
          end
        end
        m_aold[c] = av;
        m_anow[c] = (t - r_edge >= 2) ? act(m_raw[c]) : 1'b0;
        m_raw[c]  = in_sig[c];
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    t++;
    model_edge();
    #1;
    chk("level0",   32'(lvl0), 32'(m_lvl   ^ {NC{OAL}}));
    chk("press0",   32'(pr0),  32'(m_pr    ^ {NC{OAL}}));
    chk("release0", 32'(rl0),  32'(m_rl    ^ {NC{OAL}}));
    chk("hold0",    32'(hd0),  32'(m_hd[0] ^ {NC{OAL}}));
    chk("level1",   32'(lvl1), 32'(m_lvl   ^ {NC{OAL}}));
    chk("press1",   32'(pr1),  32'(m_pr    ^ {NC{OAL}}));
    chk("release1", 32'(rl1),  32'(m_rl    ^ {NC{OAL}}));
    chk("hold1",    32'(hd1),  32'(m_hd[1] ^ {NC{OAL}}));
    for (int c = 0; c < NC; c++) begin
      if (pr0[c] === 1'b1) begin n_press[c]++; last_press[c] = t; end
      if (rl0[c] === 1'b1) begin n_rel[c]++; last_rel[c] = t; end
      if (hd0[c] === 1'b1) begin
        if (n_hold0[c] == 0) first_hold0[c] = t;
        n_hold0[c]++;
      end
      if (hd1[c] === 1'b1) n_hold1[c]++;
    end
    if (hd1[0] === 1'b1) hold1_q.push_back(t);
    if (pr0 !== '0) begin pv = pr0; pv_t = t; end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int e, p, r;
    int rem [NC];

    sys_rst = 1'b1;
    in_sig  = '1;
    clr();
    run(2);
    chk("rst_level", 32'(lvl0), 32'({NC{OAL}}));
    sys_rst = 1'b0;
    run(20);

    // Clean press on ch0, then hold for 110 cycles past the press pulse
    clr();
    e = t;
    in_sig[0] = 1'b0;
    run(15);
    chk("press_lat", 32'(last_press[0] - e), 32'd11);
    chk("press_cnt", 32'(n_press[0]), 32'd1);
    chk("others_idle", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);
    chk("level_on", 32'(lvl0[0]), 32'd1);
    p = last_press[0];
    run(p + 110 - t);
    chk("hold_single_cnt", 32'(n_hold0[0]), 32'd1);
    chk("hold_single_at", 32'(first_hold0[0] - p), 32'd24);
    chk("hold_rep_cnt", 32'(hold1_q.size()), 32'd4);
    for (int i = 0; i < hold1_q.size(); i++) begin
      chk("hold_rep_at", 32'(hold1_q[i] - p), 32'(24 * (i + 1)));
    end
    in_sig[0] = 1'b1;
    run(30);
    chk("release_cnt", 32'(n_rel[0]), 32'd1);

    // Release accepted before the hold point
    clr();
    in_sig[0] = 1'b0;
    run(14);
    e = t;
    in_sig[0] = 1'b1;
    run(40);
    chk("early_rel_lat", 32'(last_rel[0] - e), 32'd11);
    chk("early_rel_hold0", 32'(n_hold0[0]), 32'd0);
    chk("early_rel_hold1", 32'(n_hold1[0]), 32'd0);
    chk("early_rel_level", 32'(lvl0[0]), 32'd0);

    // Bounce: toggle every 5 cycles, then settle low
    clr();
    for (int k = 0; k < 6; k++) begin
      in_sig[0] = k[0];
      run(5);
    end
    e = t;
    in_sig[0] = 1'b0;
    run(20);
    chk("bounce_press_cnt", 32'(n_press[0]), 32'd1);
    chk("bounce_press_lat", 32'(last_press[0] - e), 32'd11);
    chk("bounce_rel_cnt", 32'(n_rel[0]), 32'd0);
    in_sig[0] = 1'b1;
    run(30);

    // Simultaneous press on ch1 and ch3
    clr();
    e = t;
    in_sig[1] = 1'b0;
    in_sig[3] = 1'b0;
    run(15);
    chk("simul_vec", 32'(pv), 32'h0000000a);
    chk("simul_lat", 32'(pv_t - e), 32'd11);
    in_sig = '1;
    run(30);

    // Reset while the press counter is at 5; input stays low afterwards
    clr();
    e = t;
    in_sig[0] = 1'b0;
    run(8);
    sys_rst = 1'b1;
    step();
    r = t;
    sys_rst = 1'b0;
    chk("midrst_level", 32'(lvl0), 32'd0);
    chk("midrst_press", 32'(pr0), 32'd0);
    run(20);
    chk("midrst_press_cnt", 32'(n_press[0]), 32'd1);
    chk("midrst_press_lat", 32'(last_press[0] - r), 32'd11);
    in_sig = '1;
    run(30);

    // Random segments of bounce and long holds on all channels, rare resets
    for (int c = 0; c < NC; c++) rem[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NC; c++) begin
        if (rem[c] == 0) begin
          in_sig[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 60);
        end
        rem[c]--;
      end
      sys_rst = ($urandom_range(0, 399) == 0);
      step();
    end
    sys_rst = 1'b0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
